// File: rtl/platform_fx_pkg.sv
// platform_fx_pkg: shared gadget codes, effect-mask bit positions and
// level-to-pixel helpers for the platform effects controller.
package platform_fx_pkg;

   typedef enum logic [2:0] {
      EXPAND       = 3'd0,
      SHRINK       = 3'd1,
      GRAB         = 3'd2,
      FASTER_BALL  = 3'd3,
      SLOWER_BALL  = 3'd4,
      FIRE_BALL    = 3'd5,
      BIGGER_BALL  = 3'd6,
      SMALLER_BALL = 3'd7
   } gadget_e;

   localparam int FX_PLAT  = 0;
   localparam int FX_SPEED = 1;
   localparam int FX_BALL  = 2;
   localparam int FX_GRAB  = 3;
   localparam int FX_FIRE  = 4;
   localparam int FX_N     = 5;

   // Platform half-width doubles with each size level, starting at min_hw.
   function automatic int plat_half_width(input int min_hw, input int lvl);
      return min_hw << (lvl - 1);
   endfunction

   // Ball radius grows by two pixels per level, always odd.
   function automatic int ball_radius(input int lvl);
      return 2 * lvl + 1;
   endfunction

endpackage

// File: rtl/platform_fx_timer.sv
// fx_timer: frame-count lifetime of one gadget effect. A load restarts the
// countdown and beats a same-cycle tick; expire pulses combinationally on
// the tick that takes the count from 1 to 0.
import platform_fx_pkg::*;

module fx_timer #(
   parameter int TW        = 10,
   parameter int FX_FRAMES = 600
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic load,
   input  logic tick,
   output logic active,
   output logic expire
);

   logic [TW-1:0] count;

   assign active = (count != '0);
   assign expire = tick & ~load & ~clear & (count == TW'(1));

   // Countdown register: clear beats load, load beats tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (load)
         count <= TW'(FX_FRAMES);
      else if (tick && active)
         count <= count - TW'(1);
   end

endmodule

// File: rtl/platform_fx.sv
// platform_fx: platform position with wall clamping and req/ack update
// handshake, plus gadget-driven size/speed/ball/grab/fire modifiers that
// wear off after FX_FRAMES frames.
// Optional macro PLATFORM_FX_SLEW_EN: limits each position update to
// MAX_STEP pixels of travel toward the clamped target.
import platform_fx_pkg::*;

module platform_fx #(
   parameter int XW          = 10,
   parameter int YW          = 9,
   parameter int HWW         = 8,
   parameter int GW          = 3,
   parameter int SCREEN_W    = 640,
   parameter int WALL        = 16,
   parameter int PLAT_Y      = 440,
   parameter int PLAT_MIN_HW = 8,
   parameter int PLAT_LVLS   = 5,
   parameter int PLAT_DEF    = 3,
   parameter int SPD_LVLS    = 5,
   parameter int SPD_DEF     = 3,
   parameter int BALL_LVLS   = 3,
   parameter int BALL_DEF    = 2,
   parameter int FX_FRAMES   = 600,
   parameter int TW          = 10,
   parameter int MAX_STEP    = 24
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_game_start,
   input  logic           i_cal_frame,
   input  logic [XW-1:0]  i_gamepad_X,
   output logic [XW-1:0]  o_platX,
   output logic [YW-1:0]  o_platY,
   output logic [HWW-1:0] o_plat_size,
   input  logic [GW-1:0]  i_plat_gadget_effect,
   input  logic           i_plat_receive_gadget,
   input  logic           i_plat_req,
   output logic           o_plat_ack,
   output logic           o_grab,
   output logic [XW-1:0]  o_2ball_platX,
   output logic [YW-1:0]  o_2ball_platY,
   output logic [2:0]     o_ball_speedstep,
   output logic [5:0]     o_ball_size,
   output logic           o_ball_damage,
   output logic [4:0]     o_fx_active
);

   localparam int CW = XW + 1;
   localparam logic [HWW-1:0] HW_DEF = HWW'(plat_half_width(PLAT_MIN_HW, PLAT_DEF));

   logic [2:0]     plat_lvl, spd_lvl, ball_lvl;
   logic           grab, fire, ack;
   logic [XW-1:0]  plat_x;
   logic [HWW-1:0] plat_size;
   logic [HWW-1:0] hw_cur;
   logic           code_ok;
   gadget_e        code;
   logic [FX_N-1:0] fx_load, fx_active, fx_expire;
   logic [CW-1:0]  hw_ext, lo, hi, x_ext, cur_ext, target, next_ext;

   assign code_ok = i_plat_receive_gadget && (32'(i_plat_gadget_effect) < 32'd8);
   assign code    = gadget_e'(i_plat_gadget_effect[2:0]);
   assign hw_cur  = HWW'(plat_half_width(PLAT_MIN_HW, int'(plat_lvl)));

   // Route an accepted gadget code to the timer of its effect category.
   always_comb begin
      fx_load = '0;
      if (code_ok) begin
         case (code)
            EXPAND, SHRINK:             fx_load[FX_PLAT]  = 1'b1;
            FASTER_BALL, SLOWER_BALL:   fx_load[FX_SPEED] = 1'b1;
            BIGGER_BALL, SMALLER_BALL:  fx_load[FX_BALL]  = 1'b1;
            GRAB:                       fx_load[FX_GRAB]  = 1'b1;
            FIRE_BALL:                  fx_load[FX_FIRE]  = 1'b1;
            default:                    fx_load = '0;
         endcase
      end
   end

   for (genvar g = 0; g < FX_N; g++) begin : g_timer
      fx_timer #(.TW(TW), .FX_FRAMES(FX_FRAMES)) u_timer (
         .clk    (clk),
         .rst_n  (rst_n),
         .clear  (i_game_start),
         .load   (fx_load[g]),
         .tick   (i_cal_frame),
         .active (fx_active[g]),
         .expire (fx_expire[g])
      );
   end

   // Clamp the requested centre between the walls using the currently
   // registered size level, then optionally limit the travel per update.
   always_comb begin
      hw_ext  = CW'(hw_cur);
      lo      = CW'(WALL) + hw_ext;
      hi      = CW'(SCREEN_W - WALL) - hw_ext;
      x_ext   = CW'(i_gamepad_X);
      cur_ext = CW'(plat_x);
      if (x_ext < lo)
         target = lo;
      else if (x_ext > hi)
         target = hi;
      else
         target = x_ext;
`ifdef PLATFORM_FX_SLEW_EN
      if (target > cur_ext + CW'(MAX_STEP))
         next_ext = cur_ext + CW'(MAX_STEP);
      else if (target + CW'(MAX_STEP) < cur_ext)
         next_ext = cur_ext - CW'(MAX_STEP);
      else
         next_ext = target;
`else
      next_ext = target;
`endif
   end

   // Effect levels and flags: game start restores defaults, an expiring
   // timer reverts its category, and a gadget steps with saturation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         plat_lvl <= 3'(PLAT_DEF);
         spd_lvl  <= 3'(SPD_DEF);
         ball_lvl <= 3'(BALL_DEF);
         grab     <= 1'b0;
         fire     <= 1'b0;
      end else if (i_game_start) begin
         plat_lvl <= 3'(PLAT_DEF);
         spd_lvl  <= 3'(SPD_DEF);
         ball_lvl <= 3'(BALL_DEF);
         grab     <= 1'b0;
         fire     <= 1'b0;
      end else begin
         if (fx_expire[FX_PLAT])  plat_lvl <= 3'(PLAT_DEF);
         if (fx_expire[FX_SPEED]) spd_lvl  <= 3'(SPD_DEF);
         if (fx_expire[FX_BALL])  ball_lvl <= 3'(BALL_DEF);
         if (fx_expire[FX_GRAB])  grab     <= 1'b0;
         if (fx_expire[FX_FIRE])  fire     <= 1'b0;
         if (code_ok) begin
            case (code)
               EXPAND:       if (plat_lvl < 3'(PLAT_LVLS)) plat_lvl <= plat_lvl + 3'd1;
               SHRINK:       if (plat_lvl > 3'd1)          plat_lvl <= plat_lvl - 3'd1;
               FASTER_BALL:  if (spd_lvl < 3'(SPD_LVLS))   spd_lvl  <= spd_lvl + 3'd1;
               SLOWER_BALL:  if (spd_lvl > 3'd1)           spd_lvl  <= spd_lvl - 3'd1;
               BIGGER_BALL:  if (ball_lvl < 3'(BALL_LVLS)) ball_lvl <= ball_lvl + 3'd1;
               SMALLER_BALL: if (ball_lvl > 3'd1)          ball_lvl <= ball_lvl - 3'd1;
               GRAB:         grab <= 1'b1;
               FIRE_BALL:    fire <= 1'b1;
               default:      grab <= grab;
            endcase
         end
      end
   end

   // Position handshake: one ack per accepted request, never two in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack       <= 1'b0;
         plat_x    <= XW'(SCREEN_W / 2);
         plat_size <= HW_DEF;
      end else if (i_game_start) begin
         ack       <= 1'b0;
         plat_size <= HW_DEF;
      end else if (i_plat_req && !ack) begin
         ack       <= 1'b1;
         plat_size <= hw_cur;
         plat_x    <= XW'(next_ext);
      end else begin
         ack       <= 1'b0;
      end
   end

   assign o_platX          = plat_x;
   assign o_platY          = YW'(PLAT_Y);
   assign o_plat_size      = plat_size;
   assign o_plat_ack       = ack;
   assign o_grab           = grab;
   assign o_2ball_platX    = plat_x;
   assign o_2ball_platY    = YW'(PLAT_Y);
   assign o_ball_speedstep = spd_lvl;
   assign o_ball_size      = 6'(ball_radius(int'(ball_lvl)));
   assign o_ball_damage    = fire;
   assign o_fx_active      = fx_active;

endmodule

// File: tb/tb_platform_fx.sv
// tb_platform_fx: table-driven and randomized checks of platform_fx against
// a behavioural model of positions, levels and effect lifetimes.
module tb_platform_fx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       gs = 1'b0, frame = 1'b0, rcv = 1'b0, req = 1'b0;
   logic [9:0] gx = '0;
   logic [2:0] eff = '0;
   logic [9:0] platX, platX2;
   logic [8:0] platY, platY2;
   logic [7:0] psize;
   logic       ack, grab, dmg;
   logic [2:0] spd;
   logic [5:0] bsize;
   logic [4:0] fx;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   int  mPlat, mSpd, mBall, mX, mSize;
   bit  mGrab, mFire, mAck;
   int  mTmr[5];

   typedef struct {
      bit gs, frame, rcv, req;
      int x, eff;
      int eAck, eX, eSize, eFx;
   } vec_t;
   vec_t tbl[8];

   platform_fx dut (
      .clk(clk), .rst_n(rst_n), .i_game_start(gs), .i_cal_frame(frame),
      .i_gamepad_X(gx), .o_platX(platX), .o_platY(platY), .o_plat_size(psize),
      .i_plat_gadget_effect(eff), .i_plat_receive_gadget(rcv), .i_plat_req(req),
      .o_plat_ack(ack), .o_grab(grab), .o_2ball_platX(platX2), .o_2ball_platY(platY2),
      .o_ball_speedstep(spd), .o_ball_size(bsize), .o_ball_damage(dmg), .o_fx_active(fx)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelDefaults();
      mPlat = 3; mSpd = 3; mBall = 2; mGrab = 0; mFire = 0;
      mAck = 0; mSize = 32;
      foreach (mTmr[i]) mTmr[i] = 0;
   endfunction

   function automatic int modelFx();
      int m = 0;
      for (int i = 0; i < 5; i++) if (mTmr[i] > 0) m |= (1 << i);
      return m;
   endfunction

   function automatic void modelRevert(input int c);
      case (c)
         0: mPlat = 3;
         1: mSpd = 3;
         2: mBall = 2;
         3: mGrab = 0;
         default: mFire = 0;
      endcase
   endfunction

   // One clock of the game rules, evaluated on the inputs of that cycle.
   function automatic void modelStep(input bit g, input bit f, input int x,
                                     input int e, input bit r, input bit q);
      int cat, hw, lo, hi, tgt;
      if (g) begin
         modelDefaults();
         return;
      end
      if (q && !mAck) begin
         hw = 8 << (mPlat - 1);
         lo = 16 + hw;
         hi = 640 - 16 - hw;
         tgt = (x < lo) ? lo : (x > hi) ? hi : x;
`ifdef PLATFORM_FX_SLEW_EN
         if (tgt - mX > 24) mX = mX + 24;
         else if (mX - tgt > 24) mX = mX - 24;
         else mX = tgt;
`else
         mX = tgt;
`endif
         mSize = hw;
         mAck = 1;
      end else begin
         mAck = 0;
      end
      cat = -1;
      if (r) begin
         case (e)
            0, 1: cat = 0;
            3, 4: cat = 1;
            6, 7: cat = 2;
            2: cat = 3;
            default: cat = 4;
         endcase
      end
      if (f) begin
         for (int c = 0; c < 5; c++) begin
            if (c != cat && mTmr[c] > 0) begin
               mTmr[c]--;
               if (mTmr[c] == 0) modelRevert(c);
            end
         end
      end
      if (cat >= 0) begin
         case (e)
            0: if (mPlat < 5) mPlat++;
            1: if (mPlat > 1) mPlat--;
            3: if (mSpd < 5) mSpd++;
            4: if (mSpd > 1) mSpd--;
            6: if (mBall < 3) mBall++;
            7: if (mBall > 1) mBall--;
            2: mGrab = 1;
            default: mFire = 1;
         endcase
         mTmr[cat] = 600;
      end
   endfunction

   task automatic checkAll();
      checkOutput("platX", int'(platX), mX);
      checkOutput("platX2", int'(platX2), mX);
      checkOutput("platY", int'(platY), 440);
      checkOutput("platY2", int'(platY2), 440);
      checkOutput("plat_size", int'(psize), mSize);
      checkOutput("ack", int'(ack), int'(mAck));
      checkOutput("grab", int'(grab), int'(mGrab));
      checkOutput("damage", int'(dmg), int'(mFire));
      checkOutput("speed", int'(spd), mSpd);
      checkOutput("ball_size", int'(bsize), 2 * mBall + 1);
      checkOutput("fx_active", int'(fx), modelFx());
   endtask

   // Drive one cycle of inputs, advance the model, sample after the edge.
   task automatic applyStimulus(input bit g, input bit f, input int x,
                                input int e, input bit r, input bit q);
      gs = g; frame = f; gx = 10'(x); eff = 3'(e); rcv = r; req = q;
      modelStep(g, f, x, e, r, q);
      @(posedge clk);
      #1;
      checkAll();
   endtask

   task automatic pulseReset();
      gs = 0; frame = 0; rcv = 0; req = 0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      modelDefaults();
      mX = 320;
   endtask

   initial begin
      int px[8];
`ifdef PLATFORM_FX_SLEW_EN
      px = '{296, 296, 272, 272, 272, 272, 272, 296};
`else
      px = '{48, 48, 48, 48, 48, 48, 48, 496};
`endif
      tbl[0] = '{0, 0, 0, 1, 10, 0, 1, px[0], 32, 0};
      tbl[1] = '{0, 0, 0, 1, 10, 0, 0, px[1], 32, 0};
      tbl[2] = '{0, 0, 0, 1, 10, 0, 1, px[2], 32, 0};
      tbl[3] = '{0, 0, 0, 1, 10, 0, 0, px[3], 32, 0};
      tbl[4] = '{0, 0, 1, 0, 10, 0, 0, px[4], 32, 1};
      tbl[5] = '{0, 0, 1, 0, 10, 0, 0, px[5], 32, 1};
      tbl[6] = '{0, 0, 1, 0, 10, 0, 0, px[6], 32, 1};
      tbl[7] = '{0, 0, 0, 1, 630, 0, 1, px[7], 128, 1};

      modelDefaults();
      mX = 320;
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_platX", int'(platX), 320);
      checkOutput("reset_size", int'(psize), 32);
      checkOutput("reset_ball", int'(bsize), 5);
      checkOutput("reset_speed", int'(spd), 3);
      checkOutput("reset_ack", int'(ack), 0);
      checkOutput("reset_fx", int'(fx), 0);
      checkOutput("reset_flags", int'({grab, dmg}), 0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(tbl[i].gs, tbl[i].frame, tbl[i].x, tbl[i].eff, tbl[i].rcv, tbl[i].req);
         checkOutput("tbl_ack", int'(ack), tbl[i].eAck);
         checkOutput("tbl_platX", int'(platX), tbl[i].eX);
         checkOutput("tbl_size", int'(psize), tbl[i].eSize);
         checkOutput("tbl_fx0", int'(fx[0]), tbl[i].eFx);
      end

      // Fireball lasts exactly FX_FRAMES ticks
      applyStimulus(0, 0, 0, 5, 1, 0);
      checkOutput("fire_on", int'(dmg), 1);
      for (int k = 1; k <= 600; k++) begin
         applyStimulus(0, 1, 0, 0, 0, 0);
         if (k == 599) checkOutput("fire_599", int'(dmg), 1);
      end
      checkOutput("fire_600", int'(dmg), 0);
      checkOutput("fire_fx4", int'(fx[4]), 0);

      // Speed reload beats a same-cycle tick; second strobe restarts lifetime
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 3, 1, 0);
      checkOutput("speed_first", int'(spd), 4);
      for (int k = 0; k < 299; k++) applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 3, 1, 0);
      checkOutput("speed_second", int'(spd), 5);
      for (int k = 0; k < 599; k++) applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("speed_599", int'(spd), 5);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("speed_revert", int'(spd), 3);
      checkOutput("speed_fx1", int'(fx[1]), 0);

      // Game start overrides a same-cycle gadget and request
      applyStimulus(0, 0, 0, 6, 1, 0);
      checkOutput("ball_big", int'(bsize), 7);
      applyStimulus(1, 1, 100, 6, 1, 1);
      checkOutput("gs_ball", int'(bsize), 5);
      checkOutput("gs_fx", int'(fx), 0);
      checkOutput("gs_ack", int'(ack), 0);

`ifdef PLATFORM_FX_SLEW_EN
      // Slewed approach from centre toward 400
      pulseReset();
      @(posedge clk);
      #1;
      begin
         int exp[4];
         exp = '{344, 368, 392, 400};
         for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 400, 0, 0, 1);
            checkOutput("slew_step", int'(platX), exp[k]);
            applyStimulus(0, 0, 400, 0, 0, 1);
         end
      end
`endif

      // Randomized traffic against the model
      pulseReset();
      @(posedge clk);
      #1;
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                       int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
                       ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/platform_fx.md
Name: platform_fx

Overview:
- Parametrised successor of the platform controller.
- Owns platform X position, with clamping against the walls and a req/ack position-update handshake to collision.
- Owns gadget-driven modifiers: platform size, ball speed, ball size, grab and fireball.
- Adds per-effect frame-count expiry timers so gadgets wear off, plus configurable level ranges. Sits between gadget/collision logic and ball logic.

Parameters:
- XW, 10, pixel X width
- YW, 9, pixel Y width
- HWW, 8, platform half-width bus width
- GW, 3, gadget effect code width
- SCREEN_W, 640, screen width in pixels
- WALL, 16, wall thickness in pixels
- PLAT_Y, 440, fixed platform Y
- PLAT_MIN_HW, 8, half-width at size level 1; level L gives PLAT_MIN_HW<<(L-1)
- PLAT_LVLS, 5, number of platform size levels
- PLAT_DEF, 3, default platform level
- SPD_LVLS, 5, number of ball speed steps
- SPD_DEF, 3, default ball speed step
- BALL_LVLS, 3, number of ball size levels; level L gives radius 2L+1
- BALL_DEF, 2, default ball size level
- FX_FRAMES, 600, effect lifetime in frames
- TW, 10, timer width; must satisfy FX_FRAMES < 2^TW
- MAX_STEP, 24, slew limit in px per update (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_game_start  in  1  life lost or new game; restores all defaults
- i_cal_frame  in  1  one-cycle frame tick
- i_gamepad_X  in  XW  requested platform centre
- o_platX  out  XW  platform centre to collision
- o_platY  out  YW  constant PLAT_Y
- o_plat_size  out  HWW  registered half-width, latched at ack
- i_plat_gadget_effect  in  GW  gadget code
- i_plat_receive_gadget  in  1  one-cycle gadget strobe
- i_plat_req  in  1  collision requests a position update
- o_plat_ack  out  1  update-done pulse
- o_grab  out  1  grab active
- o_2ball_platX  out  XW  equal to o_platX
- o_2ball_platY  out  YW  equal to PLAT_Y
- o_ball_speedstep  out  3  current speed step
- o_ball_size  out  6  ball radius in pixels
- o_ball_damage  out  1  fireball active
- o_fx_active  out  5  timer-running mask: {fire, grab, ball_size, speed, plat_size}

Behaviour:
- Reset values:
  - platX = SCREEN_W/2
  - levels = defaults; o_plat_size = half-width(PLAT_DEF) = 32
  - o_ball_size = 5, speedstep = 3
  - grab = 0, fire = 0, ack = 0, all timers = 0, o_fx_active = 0
- Handshake:
  - If i_plat_req=1 and ack=0, the next cycle has ack=1, o_plat_size is latched from the current level, and platX is updated.
  - ack is always deasserted the cycle after it asserts.
  - A held req therefore yields ack 1,0,1,0,...
  - With req=0, ack stays 0 and platX holds.
- Clamping: L = WALL + hw and R = SCREEN_W - WALL - hw, where hw is the current level's half-width. Target is L if X<L, R if X>R, else X. Compute in XW+1 bits; no wrap.
- Gadgets, on the receive strobe:
  - EXPAND / SHRINK: platform level +1 / -1, saturating at 1..PLAT_LVLS.
  - FASTER_BALL / SLOWER_BALL: speed +1 / -1, saturating at 1..SPD_LVLS.
  - BIGGER_BALL / SMALLER_BALL: ball level +1 / -1, saturating at 1..BALL_LVLS.
  - GRAB / FIRE_BALL: set the flag.
  - Any accepted code, including a saturated one, loads that category's timer with FX_FRAMES.
  - Unknown codes are ignored.
- Timers:
  - On i_cal_frame, each nonzero timer decrements.
  - A timer transitioning 1->0 reverts its category to default: level back to *_DEF, or the flag cleared.
  - If a reload and a frame tick hit the same category in the same cycle, the reload wins with no decrement.
  - Other categories tick normally.
- Priority: i_game_start overrides everything else that cycle. It restores defaults, clears timers, and forces ack=0 next cycle. platX holds.
- Size change mid-update: the clamp uses the level registered before the gadget cycle.

Optional Feature:
- PLATFORM_FX_SLEW_EN
- Defined: on each ack, platX moves toward the clamped target by at most MAX_STEP pixels; if |target-platX| <= MAX_STEP it lands exactly.
- Undefined: platX jumps to the clamped target.

Decomposition:
- Shared package holds:
  - the gadget code enum (EXPAND, SHRINK, GRAB, FASTER_BALL, SLOWER_BALL, FIRE_BALL, BIGGER_BALL, SMALLER_BALL)
  - the fx-mask bit-index constants
  - the level-to-pixel functions
- One sub-module, fx_timer: load / tick / expire pulse, instantiated 5 times.

Test Plan:
- Reset, then req held 4 cycles with gamepad 10 -> ack pattern 0,1,0,1; platX = 48 (16+32); o_plat_size = 32.
- EXPAND x3, then req with gamepad 630 -> level saturates at 5; platX = 496 (640-16-128); fx_active[0] = 1.
- FIRE_BALL, then 600 frame ticks -> o_ball_damage = 1 through tick 599, 0 after tick 600; fx_active[4] clears.
- FASTER_BALL on the same cycle as a frame tick, 300 ticks later FASTER_BALL again -> speed 5; timer reloaded to 600; revert to 3 exactly 600 ticks after the second strobe.
- Game start on the same cycle as a BIGGER_BALL strobe -> o_ball_size = 5; timers 0; ack low.
- With PLATFORM_FX_SLEW_EN, platX = 320 and gamepad 400 -> successive acks give 344, 368, 392, 400.
